fios_mm_stream_ctrl: RTL and testbench

- Host-side sequencer and result post-processor that sits around a FIOS Montgomery multiplier core with cascaded PEs.
- Stores the a, b and p operands in local limb buffers and starts the core.
- Serves the core's a-shift, b-fetch and p-fetch requests.
- Collects the pushed result limbs, applies an optional final conditional subtraction (R >= p -> R - p), and streams the reduced result out over a valid/ready interface.
- Generalises the single-shot core wrapper to any limb width, limb count and PE count.

---
 rtl/fios_mm_stream_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_fios_mm_stream_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fios_mm_stream_ctrl.sv
// Host-side sequencer around a FIOS Montgomery core: buffers operands, serves the
// core's a/b/p requests, collects result limbs and streams out R or R - p.
module fios_mm_stream_ctrl #(
  parameter int unsigned W         = 17,
  parameter int unsigned s         = 8,
  parameter int unsigned PE_NB     = 8,
  parameter bit          FINAL_SUB = 1'b1,
  localparam int unsigned AW       = (s > 1) ? $clog2(s) : 1
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                ld_valid_i,
  output logic                ld_ready_o,
  input  logic [1:0]          ld_sel_i,
  input  logic [AW-1:0]       ld_addr_i,
  input  logic [W-1:0]        ld_data_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                core_start_o,
  output logic [PE_NB*W-1:0]  core_a_o,
  input  logic                core_a_shift_i,
  output logic [W-1:0]        core_b_o,
  input  logic                core_b_fetch_i,
  output logic [W-1:0]        core_p_o,
  input  logic                core_p_fetch_i,
  input  logic                core_res_push_i,
  input  logic [W-1:0]        core_res_i,
  input  logic                core_done_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [W-1:0]        res_data_o,
  output logic                res_last_o
);
  localparam int unsigned NWIN = (s + PE_NB - 1) / PE_NB;
  localparam int unsigned WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int unsigned CW   = $clog2(s + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [W-1:0] a_mem [s];
  logic [W-1:0] b_mem [s];
  logic [W-1:0] p_mem [s];
  logic [W-1:0] r_mem [s];
  logic [W-1:0] d_mem [s];

  logic [1:0]         state_q, state_d;
  logic [WW-1:0]      win_q, win_d;
  logic [AW-1:0]      b_idx_q, b_idx_d, p_idx_q, p_idx_d, k_q, k_d;
  logic [CW-1:0]      push_cnt_q, push_cnt_d;
  logic               borrow_q, borrow_d, use_d_q, use_d_d, err_q, err_d;
  logic               done_q, done_d, core_start_q, core_start_d;
  logic               ld_ready_q, ld_ready_d, busy_q, busy_d;
  logic               res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic [W-1:0]       res_data_q, res_data_d, core_b_q, core_b_d, core_p_q, core_p_d;
  logic [PE_NB*W-1:0] core_a_q, core_a_d;

  logic          ld_hit, push_ok, hs;
  logic [AW-1:0] push_idx;
  logic [W:0]    sub;

  assign ld_hit   = ld_valid_i && ld_ready_q && (32'(ld_addr_i) < s) && (ld_sel_i != 2'd3);
  assign push_ok  = (state_q == ST_RUN) && core_res_push_i && (push_cnt_q < CW'(s));
  assign push_idx = AW'(push_cnt_q);
  assign sub      = {1'b0, core_res_i} - {1'b0, p_mem[push_idx]} - (W+1)'(borrow_q);
  assign hs       = res_valid_q && res_ready_i;

  // a window: limb j = a[w*PE_NB + j], zero past the top limb
  function automatic logic [PE_NB*W-1:0] window(input logic [WW-1:0] w);
    logic [PE_NB*W-1:0] v;
    int unsigned idx;
    v = '0;
    for (int unsigned j = 0; j < PE_NB; j++) begin
      idx = 32'(w) * PE_NB + j;
      if (idx < s) v[j*W +: W] = a_mem[AW'(idx)];
    end
    return v;
  endfunction

  // Output limb, forwarding a result limb being written this same cycle
  function automatic logic [W-1:0] sel_res(input logic [AW-1:0] idx, input logic use_d);
    logic [W-1:0] r, dv;
    r  = r_mem[idx];
    dv = d_mem[idx];
    if (push_ok && push_idx == idx) begin
      r  = core_res_i;
      dv = sub[W-1:0];
    end
    return use_d ? dv : r;
  endfunction

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    b_idx_d      = b_idx_q;
    p_idx_d      = p_idx_q;
    k_d          = k_q;
    push_cnt_d   = push_cnt_q;
    borrow_d     = borrow_q;
    use_d_d      = use_d_q;
    err_d        = err_q;
    done_d       = 1'b0;
    core_start_d = 1'b0;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    core_p_d     = core_p_q;
    res_data_d   = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d      = ST_RUN;
        win_d        = '0;
        b_idx_d      = '0;
        p_idx_d      = '0;
        push_cnt_d   = '0;
        borrow_d     = 1'b0;
        err_d        = 1'b0;
        core_start_d = 1'b1;
        core_a_d     = window('0);
        core_b_d     = b_mem[0];
        core_p_d     = p_mem[0];
      end
      ST_RUN: begin
        if (core_a_shift_i) begin
          win_d    = (win_q == WW'(NWIN - 1)) ? '0 : win_q + WW'(1);
          core_a_d = window(win_d);
        end
        if (core_b_fetch_i) begin
          b_idx_d  = (b_idx_q == AW'(s - 1)) ? '0 : b_idx_q + AW'(1);
          core_b_d = b_mem[b_idx_d];
        end
        if (core_p_fetch_i) begin
          p_idx_d  = (p_idx_q == AW'(s - 1)) ? '0 : p_idx_q + AW'(1);
          core_p_d = p_mem[p_idx_d];
        end
        if (push_ok) begin
          push_cnt_d = push_cnt_q + CW'(1);
          borrow_d   = sub[W];
        end
        if (core_done_i) begin
          state_d    = ST_DRAIN;
          err_d      = err_q | (push_cnt_d != CW'(s));
          use_d_d    = FINAL_SUB & ~borrow_d;
          k_d        = '0;
          res_data_d = sel_res('0, use_d_d);
        end
      end
      default: begin
        if (hs) begin
          if (k_q == AW'(s - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            k_d     = '0;
          end else begin
            k_d        = k_q + AW'(1);
            res_data_d = sel_res(k_d, use_d_q);
          end
        end
      end
    endcase
    ld_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_DRAIN);
    res_last_d  = (state_d == ST_DRAIN) && (k_d == AW'(s - 1));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      b_idx_q      <= '0;
      p_idx_q      <= '0;
      k_q          <= '0;
      push_cnt_q   <= '0;
      borrow_q     <= 1'b0;
      use_d_q      <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      ld_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      res_last_q   <= 1'b0;
      res_data_q   <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_p_q     <= '0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      b_idx_q      <= b_idx_d;
      p_idx_q      <= p_idx_d;
      k_q          <= k_d;
      push_cnt_q   <= push_cnt_d;
      borrow_q     <= borrow_d;
      use_d_q      <= use_d_d;
      err_q        <= err_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
      ld_ready_q   <= ld_ready_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      res_last_q   <= res_last_d;
      res_data_q   <= res_data_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_p_q     <= core_p_d;
    end
  end

  // Limb buffers keep their contents across reset
  always_ff @(posedge clock_i) begin
    if (ld_hit) begin
      case (ld_sel_i)
        2'd0:    a_mem[ld_addr_i] <= ld_data_i;
        2'd1:    b_mem[ld_addr_i] <= ld_data_i;
        default: p_mem[ld_addr_i] <= ld_data_i;
      endcase
    end
    if (push_ok) begin
      r_mem[push_idx] <= core_res_i;
      d_mem[push_idx] <= sub[W-1:0];
    end
  end

  assign ld_ready_o   = ld_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign core_start_o = core_start_q;
  assign core_a_o     = core_a_q;
  assign core_b_o     = core_b_q;
  assign core_p_o     = core_p_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_last_o   = res_last_q;
endmodule

// File: tb/tb_fios_mm_stream_ctrl.sv
// Bench for fios_mm_stream_ctrl: two configurations (s=2/PE=2/sub on, s=10/PE=4/sub off)
// driven by a bench core model and checked against an integer-arithmetic reference.
module tb_fios_mm_stream_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ld_valid [2], start [2], shift [2], bfetch [2], pfetch [2];
  logic        push [2], cdone [2], ready [2];
  logic [1:0]  ld_sel [2];
  logic [16:0] ld_data [2], cres [2];
  logic [0:0]  la0;
  logic [3:0]  la1;
  logic        ld_ready [2], busy [2], done [2], err [2], cstart [2], rvalid [2], rlast [2];
  logic [16:0] cb [2], cp [2], rdata [2];
  logic [33:0] ca0;
  logic [67:0] ca1;

  logic [16:0] am [2][10];
  logic [16:0] bm [2][10];
  logic [16:0] pm [2][10];
  logic [16:0] rin [10];
  int checks = 0;
  int errors = 0;

  fios_mm_stream_ctrl #(.W(17), .s(2), .PE_NB(2), .FINAL_SUB(1'b1)) u_d0 (
    .clock_i(clk), .reset_i(rst), .ld_valid_i(ld_valid[0]), .ld_ready_o(ld_ready[0]),
    .ld_sel_i(ld_sel[0]), .ld_addr_i(la0), .ld_data_i(ld_data[0]), .start_i(start[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .core_start_o(cstart[0]),
    .core_a_o(ca0), .core_a_shift_i(shift[0]), .core_b_o(cb[0]), .core_b_fetch_i(bfetch[0]),
    .core_p_o(cp[0]), .core_p_fetch_i(pfetch[0]), .core_res_push_i(push[0]),
    .core_res_i(cres[0]), .core_done_i(cdone[0]), .res_valid_o(rvalid[0]),
    .res_ready_i(ready[0]), .res_data_o(rdata[0]), .res_last_o(rlast[0]));

  fios_mm_stream_ctrl #(.W(17), .s(10), .PE_NB(4), .FINAL_SUB(1'b0)) u_d1 (
    .clock_i(clk), .reset_i(rst), .ld_valid_i(ld_valid[1]), .ld_ready_o(ld_ready[1]),
    .ld_sel_i(ld_sel[1]), .ld_addr_i(la1), .ld_data_i(ld_data[1]), .start_i(start[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .core_start_o(cstart[1]),
    .core_a_o(ca1), .core_a_shift_i(shift[1]), .core_b_o(cb[1]), .core_b_fetch_i(bfetch[1]),
    .core_p_o(cp[1]), .core_p_fetch_i(pfetch[1]), .core_res_push_i(push[1]),
    .core_res_i(cres[1]), .core_done_i(cdone[1]), .res_valid_o(rvalid[1]),
    .res_ready_i(ready[1]), .res_data_o(rdata[1]), .res_last_o(rlast[1]));

  function automatic int s_of(input int d);
    return (d == 0) ? 2 : 10;
  endfunction

  function automatic int pe_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  // Expected a window from the operand model
  function automatic logic [67:0] exp_win(input int d, input int w);
    logic [67:0] v;
    int idx;
    v = '0;
    for (int j = 0; j < pe_of(d); j++) begin
      idx = w * pe_of(d) + j;
      if (idx < s_of(d)) v[17*j +: 17] = am[d][idx];
    end
    return v;
  endfunction

  function automatic logic [67:0] act_win(input int d);
    return (d == 0) ? {34'd0, ca0} : ca1;
  endfunction

  task automatic ld(input int d, input logic [1:0] sel, input int addr, input logic [16:0] data);
    ld_valid[d] = 1'b1;
    ld_sel[d]   = sel;
    ld_data[d]  = data;
    if (d == 0) la0 = 1'(addr); else la1 = 4'(addr);
    checks++;
    if (ld_ready[d] !== 1'b1) begin
      errors++; $display("FAIL ld_ready d%0d got %b want 1", d, ld_ready[d]);
    end
    @(negedge clk);
    ld_valid[d] = 1'b0;
    if (addr < s_of(d)) begin
      case (sel)
        2'd0: am[d][addr] = data;
        2'd1: bm[d][addr] = data;
        2'd2: pm[d][addr] = data;
        default: ;
      endcase
    end
  endtask

  task automatic load_all(input int d);
    for (int i = 0; i < s_of(d); i++) begin
      ld(d, 2'd0, i, 17'($urandom));
      ld(d, 2'd1, i, 17'($urandom));
      ld(d, 2'd2, i, 17'($urandom));
    end
  endtask

  // Start pulse (optionally with a same-cycle p[0] write), up to the core_start cycle
  task automatic do_start(input int d, input bit ld_p0);
    logic [67:0] ew;
    start[d] = 1'b1;
    if (ld_p0) begin
      ld_valid[d] = 1'b1; ld_sel[d] = 2'd2; ld_data[d] = 17'($urandom);
      if (d == 0) la0 = 1'b0; else la1 = 4'd0;
      pm[d][0] = ld_data[d];
    end
    @(negedge clk);
    start[d] = 1'b0; ld_valid[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1 || cstart[d] !== 1'b0 || ld_ready[d] !== 1'b0) begin
      errors++; $display("FAIL launch d%0d busy=%b cstart=%b ldrdy=%b want 1 0 0", d, busy[d], cstart[d], ld_ready[d]);
    end
    @(negedge clk);
    ew = exp_win(d, 0);
    checks++;
    if (cstart[d] !== 1'b1 || cb[d] !== bm[d][0] || cp[d] !== pm[d][0] || act_win(d) !== ew) begin
      errors++; $display("FAIL run_entry d%0d cstart=%b b=%h p=%h a=%h want 1 %h %h %h", d, cstart[d], cb[d], cp[d], act_win(d), bm[d][0], pm[d][0], ew);
    end
  endtask

  // Bench core pushes rin[0..npush-1], signals done, then the result stream is checked
  task automatic finish(input int d, input int npush, input bit same_done, input int mode, input bit chk);
    logic [169:0] rv, pv, ev;
    logic [16:0] el;
    int sn, k, cyc;
    bit r;
    sn = s_of(d);
    rv = '0; pv = '0;
    for (int i = 0; i < sn; i++) begin
      rv[17*i +: 17] = rin[i];
      pv[17*i +: 17] = pm[d][i];
    end
    ev = ((d == 0) && rv >= pv) ? rv - pv : rv;
    for (int i = 0; i < npush; i++) begin
      push[d] = 1'b1; cres[d] = rin[i];
      if (same_done && i == npush - 1) cdone[d] = 1'b1;
      @(negedge clk);
      push[d] = 1'b0; cdone[d] = 1'b0;
      if (i == 0) begin
        checks++;
        if (cstart[d] !== 1'b0) begin
          errors++; $display("FAIL cstart_pulse d%0d got %b want 0", d, cstart[d]);
        end
      end
    end
    if (!same_done) begin
      cdone[d] = 1'b1;
      @(negedge clk);
      cdone[d] = 1'b0;
    end
    checks++;
    if (err[d] !== (npush != sn) || rvalid[d] !== 1'b1) begin
      errors++; $display("FAIL drain_entry d%0d err=%b valid=%b want %b 1", d, err[d], rvalid[d], npush != sn);
    end
    if (!chk) return;
    k = 0; cyc = 0;
    while (k < sn && cyc < 200) begin
      el = ev[17*k +: 17];
      checks++;
      if (rvalid[d] !== 1'b1 || rdata[d] !== el || rlast[d] !== (k == sn - 1) || done[d] !== 1'b0) begin
        errors++; $display("FAIL res d%0d limb %0d valid=%b data=%h last=%b done=%b want 1 %h %b 0", d, k, rvalid[d], rdata[d], rlast[d], done[d], el, k == sn - 1);
      end
      case (mode)
        0: r = 1'b1;
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom);
      endcase
      ready[d] = r;
      @(negedge clk);
      if (r) k++;
      cyc++;
    end
    ready[d] = 1'b0;
    checks++;
    if (k != sn || done[d] !== 1'b1 || busy[d] !== 1'b0 || rvalid[d] !== 1'b0 || ld_ready[d] !== 1'b1) begin
      errors++; $display("FAIL drain_end d%0d limbs=%0d done=%b busy=%b valid=%b ldrdy=%b want %0d 1 0 0 1", d, k, done[d], busy[d], rvalid[d], ld_ready[d], sn);
    end
    @(negedge clk);
    checks++;
    if (done[d] !== 1'b0) begin
      errors++; $display("FAIL done_pulse d%0d got %b want 0", d, done[d]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ld_ready[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0 ||
          cstart[d] !== 1'b0 || rvalid[d] !== 1'b0 || rlast[d] !== 1'b0 || rdata[d] !== '0 ||
          cb[d] !== '0 || cp[d] !== '0 || act_win(d) !== '0) begin
        errors++; $display("FAIL reset d%0d ldrdy=%b busy=%b done=%b err=%b cstart=%b valid=%b last=%b data=%h b=%h p=%h a=%h",
                           d, ld_ready[d], busy[d], done[d], err[d], cstart[d], rvalid[d], rlast[d], rdata[d], cb[d], cp[d], act_win(d));
      end
    end
  endtask

  task automatic test_final_sub;
    ld(0, 2'd0, 0, 17'h00011); ld(0, 2'd0, 1, 17'h00022);
    ld(0, 2'd1, 0, 17'h00033); ld(0, 2'd1, 1, 17'h00044);
    ld(0, 2'd2, 0, 17'h00005); ld(0, 2'd2, 1, 17'h00000);
    ld(0, 2'd3, 0, 17'h1ABCD);
    rin[0] = 17'h00007; rin[1] = 17'h0; do_start(0, 1'b0); finish(0, 2, 1'b0, 0, 1'b1);
    rin[0] = 17'h00005; rin[1] = 17'h0; do_start(0, 1'b0); finish(0, 2, 1'b1, 0, 1'b1);
    ld(0, 2'd2, 0, 17'h00001);
    rin[0] = 17'h00000; rin[1] = 17'h1; do_start(0, 1'b0); finish(0, 2, 1'b0, 0, 1'b1);
  endtask

  task automatic test_backpressure;
    ld(0, 2'd2, 0, 17'h00005);
    rin[0] = 17'h00003; rin[1] = 17'h0; do_start(0, 1'b0); finish(0, 2, 1'b0, 1, 1'b1);
  endtask

  task automatic test_pass_through;
    for (int i = 0; i < 10; i++) ld(1, 2'd2, i, (i == 0) ? 17'h1 : 17'h0);
    for (int i = 0; i < 10; i++) rin[i] = (i == 1) ? 17'h1 : 17'h0;
    do_start(1, 1'b0); finish(1, 10, 1'b0, 0, 1'b1);
  endtask

  task automatic test_windows_fetch;
    int w, bi, pi;
    bit sh, bf, pf;
    logic [67:0] ew;
    for (int i = 0; i < 10; i++) ld(1, 2'd0, i, 17'(i + 1));
    for (int i = 0; i < 10; i++) begin
      ld(1, 2'd1, i, 17'($urandom));
      ld(1, 2'd2, i, 17'($urandom));
    end
    do_start(1, 1'b0);
    w = 0; bi = 0; pi = 0;
    for (int c = 0; c < 24; c++) begin
      sh = (c < 3) ? 1'b1 : 1'($urandom);
      bf = (c < 12) ? 1'b1 : 1'($urandom);
      pf = 1'($urandom);
      shift[1] = sh; bfetch[1] = bf; pfetch[1] = pf;
      @(negedge clk);
      shift[1] = 1'b0; bfetch[1] = 1'b0; pfetch[1] = 1'b0;
      if (sh) w = (w + 1) % 3;
      if (bf) bi = (bi + 1) % 10;
      if (pf) pi = (pi + 1) % 10;
      ew = exp_win(1, w);
      checks++;
      if (ca1 !== ew || cb[1] !== bm[1][bi] || cp[1] !== pm[1][pi]) begin
        errors++; $display("FAIL window_fetch step %0d a=%h b=%h p=%h want %h %h %h", c, ca1, cb[1], cp[1], ew, bm[1][bi], pm[1][pi]);
      end
    end
    for (int i = 0; i < 10; i++) rin[i] = 17'($urandom);
    finish(1, 10, 1'b1, 2, 1'b1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++) begin
      load_all(0);
      rin[0] = 17'($urandom);
      rin[1] = ($urandom % 3 == 0) ? pm[0][1] : 17'($urandom);
      do_start(0, 1'($urandom)); finish(0, 2, 1'($urandom), 2, 1'b1);
    end
    for (int n = 0; n < 2; n++) begin
      load_all(1);
      for (int i = 0; i < 10; i++) rin[i] = 17'($urandom);
      do_start(1, 1'($urandom)); finish(1, 10, 1'($urandom), 2, 1'b1);
    end
  endtask

  task automatic test_err_reset;
    rin[0] = 17'h00009; rin[1] = 17'h0;
    do_start(0, 1'b0); finish(0, 1, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (ld_ready[0] !== 1'b1 || err[0] !== 1'b0 || rvalid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL err_reset ldrdy=%b err=%b valid=%b busy=%b want 1 0 0 0", ld_ready[0], err[0], rvalid[0], busy[0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ld_valid[d] = 1'b0; start[d] = 1'b0; shift[d] = 1'b0; bfetch[d] = 1'b0;
      pfetch[d] = 1'b0; push[d] = 1'b0; cdone[d] = 1'b0; ready[d] = 1'b0;
      ld_sel[d] = 2'd0; ld_data[d] = '0; cres[d] = '0;
    end
    la0 = '0; la1 = '0; rst = 1'b1;
    test_reset;
    test_final_sub;
    test_backpressure;
    test_pass_through;
    test_windows_fetch;
    test_err_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
